// File: rtl/assoc_cache_if.sv
// Core request/response and memory bus bundle for assoc_cache.
// master: core/memory side driver; slave: the cache itself.
interface assoc_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic                      req_byte;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_hit;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic                      mem_ready;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/assoc_cache.sv
// Two-way set-associative write-through data cache with per-set LRU.
// Ports: clk, rst_n (sync, active-low), flush, bus (slave), load counters.
module assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    assoc_cache_if.slave bus,
    output logic [31:0] total_accesses,
    output logic [31:0] total_hits,
    output logic [31:0] total_misses
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_e;

    state_e                  state_q, state_d;
    logic [1:0][NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0]     lru_q, lru_d;
    logic [TAG-1:0]          tag_q  [2][NUM_SETS];
    logic [TAG-1:0]          tag_d  [2][NUM_SETS];
    logic [DATA_WIDTH-1:0]   data_q [2][NUM_SETS];
    logic [DATA_WIDTH-1:0]   data_d [2][NUM_SETS];
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic                    rsp_hit_q, rsp_hit_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [31:0]             acc_q, acc_d, hits_q, hits_d, miss_q, miss_d;

    logic [IDX-1:0]          req_idx, fill_idx;
    logic [TAG-1:0]          req_tag, fill_tag;
    logic [OFF-1:0]          req_lane;
    logic [1:0]              hit_w;
    logic                    hit, hit_way, victim;
    logic [NB-1:0]           req_be;
    logic [DATA_WIDTH-1:0]   req_wrep;

    assign req_idx  = bus.req_addr[IDX+OFF-1:OFF];
    assign req_tag  = bus.req_addr[ADDR_WIDTH-1:IDX+OFF];
    assign req_lane = bus.req_addr[OFF-1:0];
    assign fill_idx = addr_q[IDX+OFF-1:OFF];
    assign fill_tag = addr_q[ADDR_WIDTH-1:IDX+OFF];

    assign hit_w[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit_w[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];

    // First invalid way wins; only fall back to LRU when the set is full
    assign victim = !valid_q[0][fill_idx] ? 1'b0 :
                    !valid_q[1][fill_idx] ? 1'b1 : lru_q[fill_idx];

    // Byte stores replicate the byte across all lanes and strobe one
    assign req_be   = bus.req_byte ? NB'(1) << req_lane : '1;
    assign req_wrep = bus.req_byte ? {NB{bus.req_wdata[7:0]}} : bus.req_wdata;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        lru_d       = lru_q;
        tag_d       = tag_q;
        data_d      = data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_rdata_d = rsp_rdata_q;
        acc_d       = acc_q;
        hits_d      = hits_q;
        miss_d      = miss_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    lru_d   = '0;
                end else if (bus.req_valid) begin
                    addr_d      = {bus.req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    rsp_hit_d   = hit;
                    rsp_rdata_d = '0;
                    if (bus.req_we) begin
                        wdata_d = req_wrep;
                        be_d    = req_be;
                        state_d = WRITE;
                        if (hit) begin
                            for (int k = 0; k < NB; k++) begin
                                if (req_be[k]) begin
                                    data_d[hit_way][req_idx][8*k +: 8] =
                                        req_wrep[8*k +: 8];
                                end
                            end
                            lru_d[req_idx] = ~hit_way;
                        end
                    end else begin
                        be_d  = '1;
                        acc_d = acc_q + 32'd1;
                        if (hit) begin
                            hits_d         = hits_q + 32'd1;
                            rsp_rdata_d    = data_q[hit_way][req_idx];
                            lru_d[req_idx] = ~hit_way;
                            state_d        = RESP;
                        end else begin
                            miss_d  = miss_q + 32'd1;
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                if (bus.mem_ready) begin
                    valid_d[victim][fill_idx] = 1'b1;
                    tag_d[victim][fill_idx]   = fill_tag;
                    data_d[victim][fill_idx]  = bus.mem_rdata;
                    lru_d[fill_idx]           = ~victim;
                    rsp_rdata_d               = bus.mem_rdata;
                    rsp_hit_d                 = 1'b0;
                    state_d                   = RESP;
                end
            end
            WRITE: begin
                if (bus.mem_ready) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            lru_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_rdata_q <= '0;
            acc_q       <= '0;
            hits_q      <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            lru_q       <= lru_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_rdata_q <= rsp_rdata_d;
            acc_q       <= acc_d;
            hits_q      <= hits_d;
            miss_q      <= miss_d;
        end
    end

    // Line storage needs no reset; valid bits gate it, and reset blocks writes
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && !flush;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.mem_req    = (state_q == FILL) || (state_q == WRITE);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_be     = be_q;
    assign total_accesses = acc_q;
    assign total_hits     = hits_q;
    assign total_misses   = miss_q;
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Two-way set-associative, write-through data cache with per-set LRU replacement, a request/response handshake on the core side and a blocking single-outstanding memory interface. Sits between the core's load/store unit and data memory; the next generation of the direct-mapped cache, adding parametrised depth, associativity with replacement, byte strobes, flush and explicit miss handling.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, line/word width; one word per line; 32 or 64 only
- NUM_SETS, 8, sets per way; power of two, at least 2
- Derived: OFF = log2(DATA_WIDTH/8); IDX = log2(NUM_SETS); TAG = ADDR_WIDTH-IDX-OFF
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  invalidate all lines (single-cycle pulse)
- req_valid  in  1  core request present
- req_ready  out  1  cache can accept request
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  store width: 1 = byte, 0 = full word (ignored for loads)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data; byte stores use [7:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  load data, valid with rsp_valid on loads
- rsp_hit  out  1  request hit, valid with rsp_valid
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  word-aligned address (low OFF bits zero)
- mem_wdata  out  DATA_WIDTH  store data, byte replicated into addressed lane
- mem_be  out  DATA_WIDTH/8  byte enables; all ones for word stores and reads
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ready
- total_accesses, total_hits, total_misses  out  32 each  load counters

## Operation
- Address split: tag = addr[ADDR_WIDTH-1:IDX+OFF], index = addr[IDX+OFF-1:OFF], lane = addr[OFF-1:0].
- Per set, per way: valid, tag, data; per set: one LRU bit naming the way to replace next.
- States: IDLE, FILL, WRITE, RESP.
- req_ready = (state==IDLE) && !flush. Handshake: request accepted when req_valid && req_ready; inputs sampled only then.
- IDLE, load hit: go to RESP with data from the hitting way; LRU bit set to the other way.
- IDLE, load miss: go to FILL; mem_req=1, mem_we=0, mem_be all ones. On mem_ready: victim = first invalid way (way 0 before way 1), else LRU way; write valid/tag/mem_rdata into it, set LRU to the other way, go to RESP with rsp_rdata = mem_rdata, rsp_hit=0.
- IDLE, store: on hit, update hitting way in the accept cycle (byte: lane only; word: full) and update LRU. On miss, no allocation. Go to WRITE; mem_req=1, mem_we=1 until mem_ready, then RESP with rsp_hit = hit at acceptance.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Counters increment only on accepted loads: accesses +1; hits or misses +1. Wrap modulo 2^32. Stores never counted.
- flush in IDLE: clears all valid and LRU bits next edge; flush outside IDLE is ignored. Counters are not cleared by flush.

## Timing
- Reset (rst_n low at edge): state IDLE, all valid/LRU bits 0, counters 0, rsp_valid/rsp_hit/rsp_rdata 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, mem_be 0. req_ready reads 1 the cycle after reset is released (flush low).
- Load hit accepted at edge T: rsp_valid high in cycle T+1 to T+2.
- Miss/store accepted at T: mem_req high from T+1; if mem_ready seen at edge M, mem_req low after M, rsp_valid high in cycle after M. Minimum latency 2 cycles (mem_ready in first request cycle).
- mem_addr/mem_we/mem_wdata/mem_be stable while mem_req is high.
- One outstanding request; req_ready low from acceptance until back in IDLE.
- Reset mid-FILL/WRITE: request abandoned, mem_req low after the reset edge, no rsp_valid, no line written.
- Fill and LRU update of a set occur on the same edge; a load to the same address accepted on the next IDLE cycle hits.

## Test plan
- Reset then load 0x100 (mem_rdata 0xDEADBEEF, mem_ready after 3 cycles) -> rsp_hit=0, rsp_rdata=0xDEADBEEF; repeat load -> hit, rsp_valid one cycle after acceptance; counters 2/1/1.
- Loads 0x000, 0x020, 0x040 (NUM_SETS=8, same set 0) -> third evicts way holding 0x000; load 0x020 hits, load 0x000 misses.
- Byte store 0x101 data 0xAA after 0x100 cached -> mem_be=4'b0010, mem_wdata=0xAAAAAAAA; following load 0x100 hits with 0xDEADAAEF; counters unchanged by store.
- Store miss to 0x200 -> memory write issued, rsp_hit=0; subsequent load 0x200 misses (no allocate).
- flush pulse after caching 0x100 -> req_ready low that cycle; next load 0x100 misses.
- Reset asserted during FILL -> mem_req low next cycle, no rsp_valid, load of same address afterwards misses.
